bsg_axil_to_irq: RTL and testbench
==================================

// Module: bsg_axil_to_irq
// PURPOSE
//  AXI4-Lite subordinate; receiving end of the IRQ-notification write protocol. An interrupt
//  source signals event i with a single write to irq_addr_p + 4*i. This block latches each
//  write into pending bit i, drives it as a level interrupt, and clears it on ack or readback.
//  Sits on the PS/host AXI-Lite subordinate fabric, in front of the local interrupt consumer.
// PARAMETERS
//  axil_data_width_p  32            AXI-Lite data width; must be 32.
//  axil_addr_width_p  32            AXI-Lite address width.
//  irq_sources_p      2             Number of interrupt lines (N), 1..32.
//  irq_addr_p         32'h00000000  Byte base of the IRQ window, 4-byte aligned.
// PORTS
//  clk_i             in   1      Clock.
//  reset_i           in   1      Synchronous, active-high reset.
//  s_axil_awaddr_i   in   AW     Write address.
//  s_axil_awprot_i   in   3      Ignored.
//  s_axil_awvalid_i  in   1      / s_axil_awready_o out 1: AW handshake.
//  s_axil_wdata_i    in   32     Ignored; the write event is the notification.
//  s_axil_wstrb_i    in   4      Write strobes.
//  s_axil_wvalid_i   in   1      / s_axil_wready_o out 1: W handshake.
//  s_axil_bresp_o    out  2      00 OKAY, 10 SLVERR.
//  s_axil_bvalid_o   out  1      / s_axil_bready_i in 1: B handshake.
//  s_axil_araddr_i   in   AW     Read address; s_axil_arprot_i in 3 is ignored.
//  s_axil_arvalid_i  in   1      / s_axil_arready_o out 1: AR handshake.
//  s_axil_rdata_o    out  32     Read data.
//  s_axil_rresp_o    out  2      00 OKAY, 10 SLVERR.
//  s_axil_rvalid_o   out  1      / s_axil_rready_i in 1: R handshake.
//  irq_o             out  N      Level interrupt; equals the pending register.
//  irq_ack_i         in   N      Per-line clear; one-cycle pulse or level.
// BEHAVIOUR
//  Reset: pending, irq_o, bvalid_o, rvalid_o, bresp_o, rresp_o, rdata_o all 0.
//   awready_o and wready_o are 1 on the first cycle after reset.
//  Decode: off = addr - irq_addr_p (mod 2^AW).
//   Hit iff addr[1:0]==0 and off < 4*N (unsigned compare). Index = off>>2.
//  Write path: AW and W each have a one-entry holding register.
//   awready_o = AW slot empty; wready_o = W slot empty; the two channels are accepted
//   independently and in either order.
//   Commit happens in the cycle both slots are full and bvalid_o=0.
//    - Hit and wstrb!=0: pending[idx] is set. Otherwise pending is unchanged.
//    - Both slots are freed.
//    - Next cycle: bvalid_o=1, bresp=OKAY on hit, SLVERR on miss.
//    - wstrb==0 on a hit is OKAY with no effect.
//   bvalid_o holds until bready_i. No new commit happens while bvalid_o=1.
//   Both slots may refill during that time.
//  Read path: arready_o = !rvalid_o.
//   On AR accept, the next cycle gives rvalid_o=1 and:
//    - hit: rdata = {31'b0, pending[idx]}, rresp=OKAY.
//    - miss: rdata = 0, rresp=SLVERR.
//   R outputs hold until rready_i; arready_o rises the cycle after the R handshake.
//  Pending update per line, each cycle, in priority order:
//   1. Set from a write commit wins.
//   2. Otherwise irq_ack_i[i] (or read-clear, below) clears the bit.
//   3. Otherwise the bit holds.
//   Repeated sets while pending coalesce into one bit; there is no counting.
//  irq_o = pending register: set appears 1 cycle after commit, clear 1 cycle after ack.
//  Throughput: 1 write per 2 cycles when bready_i=1 (commit, then B).
//   Read and write paths are fully independent.
//  Reset mid-transaction: held AW/W and in-flight B/R are dropped with no response.
//   The initiator must also be reset.
// CONFIGURATION
//  `BSG_AXIL_TO_IRQ_CLEAR_ON_READ_EN
//   Defined: an OKAY read of word i returns the pre-clear value of pending[i] and clears it
//   on the AR accept cycle. A write commit to the same line in that cycle wins (stays set).
//   Undefined: reads never modify state; only irq_ack_i clears.
// TESTING
//  1 Reset, N=2, base 0x1000: write 0x1004 -> bresp 00, irq_o=2'b10 one cycle after commit.
//  2 W presented 3 cycles before AW (0x1000) -> both held; commit on AW accept; irq_o[0]=1.
//  3 Write to 0x1000 and irq_ack_i[0]=1 in the commit cycle -> pending[0] stays 1.
//     Ack alone next cycle -> irq_o[0]=0.
//  4 Write 0x1008 (out of range) and 0x1002 (misaligned) -> bresp 10 each, irq_o unchanged.
//  5 bready_i=0 for 5 cycles with a new AW+W queued -> bvalid held, no second commit.
//     Second commit follows the B handshake.
//  6 Read 0x1004 with pending[1]=1 -> rdata 1, rresp 00.
//     With _EN: a re-read returns 0 and irq_o[1]=0. Without _EN: still 1.

Source files
------------

// File: rtl/bsg_axil_to_irq.sv
// bsg_axil_to_irq
//   AXI4-Lite subordinate that turns single-beat writes into level interrupts.
//   A write to irq_addr_p + 4*i sets pending bit i; irq_o mirrors the pending
//   register. A pending bit is cleared by irq_ack_i[i] or, optionally, by
//   reading the word back.
//
//   Configuration macro: BSG_AXIL_TO_IRQ_CLEAR_ON_READ_EN
//     defined   - an OKAY read of word i returns pending[i] and clears it
//     undefined - reads never modify state
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   s_axil_aw*            write address channel (awprot ignored)
//   s_axil_w*             write data channel (wdata ignored, wstrb==0 is a no-op)
//   s_axil_b*             write response, OKAY on hit, SLVERR on miss
//   s_axil_ar*            read address channel (arprot ignored)
//   s_axil_r*             read data: {31'b0, pending[idx]} on hit, 0/SLVERR on miss
//   irq_o                 level interrupts, equal to the pending register
//   irq_ack_i             per-line clear (pulse or level)

module bsg_axil_to_irq #(
  parameter int                             axil_data_width_p = 32,
  parameter int                             axil_addr_width_p = 32,
  parameter int                             irq_sources_p     = 2,
  parameter logic [axil_addr_width_p-1:0]   irq_addr_p        = '0
) (
  input  logic                              clk_i,
  input  logic                              reset_i,

  input  logic [axil_addr_width_p-1:0]      s_axil_awaddr_i,
  input  logic [2:0]                        s_axil_awprot_i,
  input  logic                              s_axil_awvalid_i,
  output logic                              s_axil_awready_o,

  input  logic [axil_data_width_p-1:0]      s_axil_wdata_i,
  input  logic [(axil_data_width_p/8)-1:0]  s_axil_wstrb_i,
  input  logic                              s_axil_wvalid_i,
  output logic                              s_axil_wready_o,

  output logic [1:0]                        s_axil_bresp_o,
  output logic                              s_axil_bvalid_o,
  input  logic                              s_axil_bready_i,

  input  logic [axil_addr_width_p-1:0]      s_axil_araddr_i,
  input  logic [2:0]                        s_axil_arprot_i,
  input  logic                              s_axil_arvalid_i,
  output logic                              s_axil_arready_o,

  output logic [axil_data_width_p-1:0]      s_axil_rdata_o,
  output logic [1:0]                        s_axil_rresp_o,
  output logic                              s_axil_rvalid_o,
  input  logic                              s_axil_rready_i,

  output logic [irq_sources_p-1:0]          irq_o,
  input  logic [irq_sources_p-1:0]          irq_ack_i
);

  localparam int AW = axil_addr_width_p;
  localparam int DW = axil_data_width_p;
  localparam int N  = irq_sources_p;
  localparam int SW = DW / 8;

  localparam logic [AW-1:0] windowBytes = AW'(4 * N);
  localparam logic [1:0]    respOkay    = 2'b00;
  localparam logic [1:0]    respSlverr  = 2'b10;

  // One-hot decode of an address into the IRQ window. The offset is taken
  // modulo 2^AW, so addresses below the base wrap to huge offsets and miss.
  // An all-zero result means miss (misaligned or out of range).
  function automatic logic [N-1:0] decodeHit(input logic [AW-1:0] addr);
    logic [AW-1:0] off;
    decodeHit = '0;
    off       = addr - irq_addr_p;
    if ((addr[1:0] == 2'b00) && (off < windowBytes)) begin
      for (int i = 0; i < N; i++) begin
        if ((off >> 2) == AW'(i)) decodeHit[i] = 1'b1;
      end
    end
  endfunction

  // Write-side holding slots and response
  logic          awFull_q, awFull_d;
  logic [AW-1:0] awAddr_q, awAddr_d;
  logic          wFull_q,  wFull_d;
  logic [SW-1:0] wStrb_q,  wStrb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q,  bresp_d;

  // Read-side response registers
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q,  rdata_d;
  logic [1:0]    rresp_q,  rresp_d;

  // Interrupt state
  logic [N-1:0]  pending_q, pending_d;

  logic          commit;
  logic          arAccept;
  logic [N-1:0]  writeHitVec;
  logic [N-1:0]  readHitVec;
  logic [N-1:0]  setVec;
  logic [N-1:0]  clearVec;

  assign s_axil_awready_o = ~awFull_q;
  assign s_axil_wready_o  = ~wFull_q;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_arready_o = ~rvalid_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;
  assign irq_o            = pending_q;

  // A commit needs both halves of the write and a free B channel; holding
  // off while bvalid is up keeps at most one response outstanding.
  assign commit      = awFull_q & wFull_q & ~bvalid_q;
  assign writeHitVec = decodeHit(awAddr_q);
  assign setVec      = (commit && (wStrb_q != '0)) ? writeHitVec : '0;

  assign arAccept    = s_axil_arvalid_i & ~rvalid_q;
  assign readHitVec  = decodeHit(s_axil_araddr_i);

  // Write path: AW and W fill their slots independently; a commit empties
  // both and raises the B response, which then waits for bready.
  always_comb begin
    awFull_d = awFull_q;
    awAddr_d = awAddr_q;
    wFull_d  = wFull_q;
    wStrb_d  = wStrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;

    if (bvalid_q && s_axil_bready_i) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      awFull_d = 1'b0;
      wFull_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = (|writeHitVec) ? respOkay : respSlverr;
    end

    if (s_axil_awvalid_i && !awFull_q) begin
      awFull_d = 1'b1;
      awAddr_d = s_axil_awaddr_i;
    end

    if (s_axil_wvalid_i && !wFull_q) begin
      wFull_d = 1'b1;
      wStrb_d = s_axil_wstrb_i;
    end
  end

  // Read path: an accepted AR produces the R beat on the next cycle; the
  // beat is held until rready and AR is blocked meanwhile.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (rvalid_q && s_axil_rready_i) begin
      rvalid_d = 1'b0;
    end

    if (arAccept) begin
      rvalid_d   = 1'b1;
      rdata_d    = '0;
      rdata_d[0] = |(pending_q & readHitVec);
      rresp_d    = (|readHitVec) ? respOkay : respSlverr;
    end
  end

  // Pending update: a commit set beats any clear in the same cycle, and
  // repeated sets simply coalesce into the single bit.
  always_comb begin
    clearVec = irq_ack_i;
`ifdef BSG_AXIL_TO_IRQ_CLEAR_ON_READ_EN
    if (arAccept) begin
      clearVec = clearVec | readHitVec;
    end
`endif
    pending_d = setVec | (pending_q & ~clearVec);
  end

  // State registers; reset drops any held request or in-flight response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      awFull_q  <= 1'b0;
      awAddr_q  <= '0;
      wFull_q   <= 1'b0;
      wStrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      pending_q <= '0;
    end else begin
      awFull_q  <= awFull_d;
      awAddr_q  <= awAddr_d;
      wFull_q   <= wFull_d;
      wStrb_q   <= wStrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pending_q <= pending_d;
    end
  end

  // Inputs that carry no information for this block.
  logic unusedInputs;
  assign unusedInputs = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_wdata_i};

endmodule

// File: tb/tb_bsg_axil_to_irq.sv
// Testbench for bsg_axil_to_irq: N=2 interrupt lines at base 0x1000.
// Directed scenarios followed by randomized write/read/ack operations, all
// checked against a transaction-level model of the pending bits.

module tb_bsg_axil_to_irq;

  localparam int          N    = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          clk_i;
  logic          reset_i;
  logic [31:0]   s_axil_awaddr_i;
  logic [2:0]    s_axil_awprot_i;
  logic          s_axil_awvalid_i;
  logic          s_axil_awready_o;
  logic [31:0]   s_axil_wdata_i;
  logic [3:0]    s_axil_wstrb_i;
  logic          s_axil_wvalid_i;
  logic          s_axil_wready_o;
  logic [1:0]    s_axil_bresp_o;
  logic          s_axil_bvalid_o;
  logic          s_axil_bready_i;
  logic [31:0]   s_axil_araddr_i;
  logic [2:0]    s_axil_arprot_i;
  logic          s_axil_arvalid_i;
  logic          s_axil_arready_o;
  logic [31:0]   s_axil_rdata_o;
  logic [1:0]    s_axil_rresp_o;
  logic          s_axil_rvalid_o;
  logic          s_axil_rready_i;
  logic [N-1:0]  irq_o;
  logic [N-1:0]  irq_ack_i;

  int            errorCount = 0;
  int            checkCount = 0;
  logic [N-1:0]  modelPending;

  bsg_axil_to_irq #(
    .axil_data_width_p (32),
    .axil_addr_width_p (32),
    .irq_sources_p     (N),
    .irq_addr_p        (BASE)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .s_axil_awaddr_i  (s_axil_awaddr_i),
    .s_axil_awprot_i  (s_axil_awprot_i),
    .s_axil_awvalid_i (s_axil_awvalid_i),
    .s_axil_awready_o (s_axil_awready_o),
    .s_axil_wdata_i   (s_axil_wdata_i),
    .s_axil_wstrb_i   (s_axil_wstrb_i),
    .s_axil_wvalid_i  (s_axil_wvalid_i),
    .s_axil_wready_o  (s_axil_wready_o),
    .s_axil_bresp_o   (s_axil_bresp_o),
    .s_axil_bvalid_o  (s_axil_bvalid_o),
    .s_axil_bready_i  (s_axil_bready_i),
    .s_axil_araddr_i  (s_axil_araddr_i),
    .s_axil_arprot_i  (s_axil_arprot_i),
    .s_axil_arvalid_i (s_axil_arvalid_i),
    .s_axil_arready_o (s_axil_arready_o),
    .s_axil_rdata_o   (s_axil_rdata_o),
    .s_axil_rresp_o   (s_axil_rresp_o),
    .s_axil_rvalid_o  (s_axil_rvalid_o),
    .s_axil_rready_i  (s_axil_rready_i),
    .irq_o            (irq_o),
    .irq_ack_i        (irq_ack_i)
  );

  // Free-running 10 ns clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Compare one observation against its expected value and count it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Park every input at its idle value
  task automatic applyStimulus();
    s_axil_awaddr_i  = '0;
    s_axil_awprot_i  = '0;
    s_axil_awvalid_i = 1'b0;
    s_axil_wdata_i   = '0;
    s_axil_wstrb_i   = '0;
    s_axil_wvalid_i  = 1'b0;
    s_axil_bready_i  = 1'b1;
    s_axil_araddr_i  = '0;
    s_axil_arprot_i  = '0;
    s_axil_arvalid_i = 1'b0;
    s_axil_rready_i  = 1'b1;
    irq_ack_i        = '0;
  endtask

  // Reference decode: aligned and inside [BASE, BASE + 4N)
  function automatic bit expHit(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'(4 * N));
  endfunction

  function automatic int expIndex(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Full write transaction with AW and W together; ack is held during the
  // commit cycle so set-versus-clear priority can be exercised
  task automatic writeTxn(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [N-1:0] ack);
    logic [N-1:0] setBit;
    s_axil_awaddr_i  = addr;
    s_axil_awvalid_i = 1'b1;
    s_axil_wdata_i   = $urandom;
    s_axil_wstrb_i   = strb;
    s_axil_wvalid_i  = 1'b1;
    checkOutput("wr_awready", {31'b0, s_axil_awready_o}, 32'd1);
    checkOutput("wr_wready",  {31'b0, s_axil_wready_o},  32'd1);
    tick();
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    irq_ack_i        = ack;
    tick();
    irq_ack_i = '0;
    setBit = '0;
    if (expHit(addr) && strb != 4'b0) setBit[expIndex(addr)] = 1'b1;
    modelPending = (modelPending & ~ack) | setBit;
    checkOutput("wr_bvalid", {31'b0, s_axil_bvalid_o}, 32'd1);
    checkOutput("wr_bresp",  {30'b0, s_axil_bresp_o}, expHit(addr) ? 32'd0 : 32'd2);
    checkOutput("wr_irq",    32'(irq_o), 32'(modelPending));
    tick();
    checkOutput("wr_bdone",  {31'b0, s_axil_bvalid_o}, 32'd0);
  endtask

  // Single read; with clear-on-read, an OKAY read consumes the pending bit
  task automatic readTxn(input logic [31:0] addr);
    logic [31:0] expData;
    s_axil_araddr_i  = addr;
    s_axil_arvalid_i = 1'b1;
    checkOutput("rd_arready", {31'b0, s_axil_arready_o}, 32'd1);
    tick();
    s_axil_arvalid_i = 1'b0;
    expData = '0;
    if (expHit(addr)) begin
      expData[0] = modelPending[expIndex(addr)];
`ifdef BSG_AXIL_TO_IRQ_CLEAR_ON_READ_EN
      modelPending[expIndex(addr)] = 1'b0;
`endif
    end
    checkOutput("rd_rvalid", {31'b0, s_axil_rvalid_o}, 32'd1);
    checkOutput("rd_rdata",  s_axil_rdata_o, expData);
    checkOutput("rd_rresp",  {30'b0, s_axil_rresp_o}, expHit(addr) ? 32'd0 : 32'd2);
    checkOutput("rd_irq",    32'(irq_o), 32'(modelPending));
    tick();
    checkOutput("rd_rdone",  {31'b0, s_axil_rvalid_o}, 32'd0);
  endtask

  // One-cycle acknowledge pulse
  task automatic ackTxn(input logic [N-1:0] ack);
    irq_ack_i = ack;
    tick();
    irq_ack_i = '0;
    modelPending = modelPending & ~ack;
    checkOutput("ack_irq", 32'(irq_o), 32'(modelPending));
  endtask

  function automatic logic [31:0] randomAddr();
    case ($urandom_range(0, 5))
      0:       return BASE + 32'(4 * $urandom_range(0, N - 1));
      1:       return BASE + 32'(4 * N);
      2:       return BASE + 32'($urandom_range(1, 3));
      3:       return BASE - 32'd4;
      4:       return $urandom;
      default: return BASE + 32'(4 * $urandom_range(0, N + 2));
    endcase
  endfunction

  initial begin
    modelPending = '0;
    applyStimulus();
    reset_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;

    // Reset state
    checkOutput("rst_irq",     32'(irq_o), 32'd0);
    checkOutput("rst_bvalid",  {31'b0, s_axil_bvalid_o}, 32'd0);
    checkOutput("rst_rvalid",  {31'b0, s_axil_rvalid_o}, 32'd0);
    checkOutput("rst_bresp",   {30'b0, s_axil_bresp_o}, 32'd0);
    checkOutput("rst_rresp",   {30'b0, s_axil_rresp_o}, 32'd0);
    checkOutput("rst_rdata",   s_axil_rdata_o, 32'd0);
    checkOutput("rst_awready", {31'b0, s_axil_awready_o}, 32'd1);
    checkOutput("rst_wready",  {31'b0, s_axil_wready_o},  32'd1);
    checkOutput("rst_arready", {31'b0, s_axil_arready_o}, 32'd1);

    // Basic hit on line 1
    writeTxn(BASE + 32'h4, 4'hF, '0);
    checkOutput("t1_irq", 32'(irq_o), 32'h2);

    // W arrives three cycles before AW
    ackTxn('1);
    s_axil_wstrb_i  = 4'hF;
    s_axil_wvalid_i = 1'b1;
    tick();
    s_axil_wvalid_i = 1'b0;
    repeat (2) tick();
    checkOutput("t2_wready_held", {31'b0, s_axil_wready_o},  32'd0);
    checkOutput("t2_awready",     {31'b0, s_axil_awready_o}, 32'd1);
    checkOutput("t2_no_b",        {31'b0, s_axil_bvalid_o},  32'd0);
    tick();
    s_axil_awaddr_i  = BASE;
    s_axil_awvalid_i = 1'b1;
    tick();
    s_axil_awvalid_i = 1'b0;
    tick();
    modelPending[0] = 1'b1;
    checkOutput("t2_bvalid", {31'b0, s_axil_bvalid_o}, 32'd1);
    checkOutput("t2_irq",    32'(irq_o), 32'(modelPending));
    tick();

    // Set wins over ack in the commit cycle, then ack alone clears
    writeTxn(BASE, 4'hF, 2'b01);
    checkOutput("t3_set_wins", {31'b0, irq_o[0]}, 32'd1);
    ackTxn(2'b01);
    checkOutput("t3_cleared", {31'b0, irq_o[0]}, 32'd0);

    // Out-of-range, misaligned and zero-strobe writes
    writeTxn(BASE + 32'h8, 4'hF, '0);
    writeTxn(BASE + 32'h2, 4'hF, '0);
    writeTxn(BASE + 32'h4, 4'h0, '0);
    writeTxn(BASE - 32'h4, 4'hF, '0);

    // Back-pressured B with a second write queued behind it
    ackTxn('1);
    s_axil_bready_i  = 1'b0;
    s_axil_awaddr_i  = BASE;
    s_axil_awvalid_i = 1'b1;
    s_axil_wstrb_i   = 4'h1;
    s_axil_wvalid_i  = 1'b1;
    tick();
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    tick();
    modelPending[0] = 1'b1;
    checkOutput("t5_first_b", {31'b0, s_axil_bvalid_o}, 32'd1);
    s_axil_awaddr_i  = BASE + 32'h4;
    s_axil_awvalid_i = 1'b1;
    s_axil_wvalid_i  = 1'b1;
    tick();
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5_b_held",  {31'b0, s_axil_bvalid_o},  32'd1);
      checkOutput("t5_no_2nd",  32'(irq_o), 32'(modelPending));
      checkOutput("t5_aw_full", {31'b0, s_axil_awready_o}, 32'd0);
      tick();
    end
    s_axil_bready_i = 1'b1;
    tick();
    checkOutput("t5_b_drop", {31'b0, s_axil_bvalid_o}, 32'd0);
    checkOutput("t5_irq_pre", 32'(irq_o), 32'(modelPending));
    tick();
    modelPending[1] = 1'b1;
    checkOutput("t5_second_b", {31'b0, s_axil_bvalid_o}, 32'd1);
    checkOutput("t5_second_resp", {30'b0, s_axil_bresp_o}, 32'd0);
    checkOutput("t5_irq", 32'(irq_o), 32'(modelPending));
    tick();

    // Readback of line 1, repeated, then some misses
    readTxn(BASE + 32'h4);
    readTxn(BASE + 32'h4);
    readTxn(BASE + 32'h8);
    readTxn(BASE + 32'h1);
    readTxn(BASE);

    // Randomized mix of operations
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: writeTxn(randomAddr(),
                    ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
        1: readTxn(randomAddr());
        default: ackTxn(N'($urandom));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
